wb_stage: RTL and testbench
===========================

Name: wb_stage

Overview:
- Final pipeline stage of the RV64 pipelined core. It sits between the MEM stage and the register file write port.
- Accepts one retiring instruction per cycle from MEM over a valid/ready handshake and formats load data (byte/half/word extraction with sign or zero extension).
- Registers the result and drives the regfile write port plus a same-cycle forwarding bus for decode, because regfile reads return the pre-write value.
- Counts retired instructions and halts the pipeline on EBREAK.

Parameters:
- XLEN, 64, datapath width.
- RADDR_W, 5, register address width.
- EBREAK_INST, 32'h0010_0073, encoding that triggers halt.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- mem_valid_i  in  1  MEM stage presents an instruction
- mem_ready_o  out  1  WB can accept this cycle
- mem_pc_i  in  64  instruction PC
- mem_inst_i  in  32  instruction word
- mem_rd_i  in  5  destination register
- mem_rd_wen_i  in  1  instruction writes rd
- mem_is_load_i  in  1  result comes from memory
- mem_ld_type_i  in  3  load funct3
- mem_addr_lo_i  in  3  load address bits [2:0]
- mem_alu_res_i  in  64  ALU/CSR result
- mem_rdata_i  in  64  raw 64-bit memory doubleword
- hold_i  in  1  debug stall; blocks accept
- rf_wen_o  out  1  regfile write enable
- rf_waddr_o  out  5  regfile write address
- rf_wdata_o  out  64  regfile write data
- fwd_valid_o  out  1  equals rf_wen_o, for decode bypass
- fwd_rd_o  out  5  equals rf_waddr_o
- fwd_data_o  out  64  equals rf_wdata_o
- commit_o  out  1  one-cycle pulse per retired instruction
- commit_pc_o  out  64  PC of the retiring instruction
- commit_inst_o  out  32  instruction word of the retiring instruction
- retire_cnt_o  out  64  retired instruction count
- ld_err_o  out  1  retiring load had an illegal type or misaligned address
- halt_o  out  1  EBREAK retired; pipeline stopped

Behaviour:
Reset (synchronous, while rst=1):
- All registered outputs are 0: wb_valid, rd, wen, wdata, pc, inst, retire_cnt, ld_err.
- State is RUN.

Handshake:
- mem_ready_o = (state==RUN) & ~hold_i. This is combinational; it is 0 during rst.
- Accept happens when mem_valid_i & mem_ready_o at a rising edge. The formatted result is latched at that edge and wb_valid=1.
- With no accept at an edge, wb_valid=0 on the next cycle (bubble). WB never holds an instruction for more than one cycle.

Outputs derived from latched state:
- rf_wen_o = wb_valid & wen & (rd!=0). Writes to x0 are suppressed here as well as in the regfile.
- commit_o = wb_valid. commit_pc_o and commit_inst_o are valid only while commit_o=1.
- Latency: accept at edge N, write port active in cycle N..N+1, regfile updated at edge N+1.

Load formatting (combinational on the input side, before the latch):
- Data selection is rf data = is_load ? formatted : alu_res.
- 000 LB: byte at addr_lo, sign-extended.
- 100 LBU: byte at addr_lo, zero-extended.
- 001 LH / 101 LHU: halfword at {addr_lo[2:1],0}, sign-extended / zero-extended.
- 010 LW / 110 LWU: word at {addr_lo[2],00}, sign-extended / zero-extended.
- 011 LD: full doubleword.
- 111: data is 0 and ld_err is set.
- A misaligned halfword, word or doubleword address (addr_lo[0]=1 for H; addr_lo[1:0]!=0 for W; !=0 for D) sets ld_err. Data is still taken from the aligned-down lane and the write still occurs.
- ld_err_o is registered with the instruction and is valid only with commit_o. It is 0 for non-loads.

Retire counter:
- Increments by 1 at every edge where wb_valid=1.
- Wraps from 2^64-1 to 0.

State machine (RUN, HALT):
- RUN -> HALT at the edge after a cycle where wb_valid=1 and inst==EBREAK_INST. The EBREAK itself commits and is counted.
- HALT: mem_ready_o=0, halt_o=1, no further accepts. Exit only by rst.
- rst asserted mid-operation discards the latched instruction; no write occurs on the following cycle.

Simultaneous events:
- hold_i=1 together with mem_valid_i: no accept, bubble next cycle, MEM must hold its inputs.
- An EBREAK with rd_wen is illegal by encoding, but if it occurs the write is still performed.

Decomposition:
- Shared package (define file) holds: XLEN, the ZERO64 constant, RST/WEN enable levels, load funct3 codes (LB..LWU), the EBREAK encoding, and the state encodings RUN=1'b0, HALT=1'b1.
- One sub-module: wb_load_align. Inputs are ld_type, addr_lo and rdata; outputs are the formatted 64-bit data and ld_err. It is purely combinational.

Test Plan:
- Reset then ALU op: rd=5, alu_res=64'h1234 accepted -> next cycle rf_wen=1, waddr=5, wdata=64'h1234, commit=1, retire_cnt increments 0->1 at the following edge.
- LB at addr_lo=3 with rdata=64'h0000_0000_80FF_7F00 -> wdata=64'hFFFF_FFFF_FFFF_FF80. LBU, same inputs -> 64'h80.
- LW at addr_lo=4 with rdata=64'h8000_0001_xxxx_xxxx -> 64'hFFFF_FFFF_8000_0001. LWU, same inputs -> 64'h0000_0000_8000_0001. LH at addr_lo=1 -> ld_err=1.
- Write to rd=0 with rd_wen=1 -> rf_wen=0, commit=1, counter still increments.
- hold_i=1 for 2 cycles with mem_valid=1 -> mem_ready=0, two bubbles, then the held instruction commits exactly once.
- EBREAK accepted -> commit=1 with inst=32'h00100073, next cycle halt_o=1 and mem_ready=0 persist. A subsequent rst clears halt and zeroes retire_cnt.

Source files
------------

// File: rtl/wb_stage_pkg.sv
// wb_stage_pkg: shared widths, load funct3 codes, EBREAK encoding and FSM states
package wb_stage_pkg;
  localparam int XLEN = 64;
  localparam int RADDR_W = 5;
  localparam logic [XLEN-1:0] ZERO64 = '0;
  localparam logic RST_ACTIVE = 1'b1;
  localparam logic WEN_ACTIVE = 1'b1;
  localparam logic [2:0] LB = 3'b000;
  localparam logic [2:0] LH = 3'b001;
  localparam logic [2:0] LW = 3'b010;
  localparam logic [2:0] LD = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;
  localparam logic [31:0] EBREAK_INST = 32'h0010_0073;
  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;
endpackage

// File: rtl/wb_load_align.sv
// wb_load_align: extracts and extends load data from a raw doubleword, flags bad type or misalignment
module wb_load_align
  import wb_stage_pkg::*;
(
  input  logic [2:0]      ld_type,
  input  logic [2:0]      addr_lo,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data,
  output logic            ld_err
);
  logic [7:0] b;
  logic [15:0] h;
  logic [31:0] w;
  // misaligned accesses still read the aligned-down lane
  assign b = rdata[{addr_lo, 3'b000} +: 8];
  assign h = rdata[{addr_lo[2:1], 4'b0000} +: 16];
  assign w = rdata[{addr_lo[2], 5'b00000} +: 32];
  always_comb begin
    data = ZERO64;
    ld_err = 1'b0;
    case (ld_type)
      LB:  data = {{(XLEN-8){b[7]}}, b};
      LBU: data = {{(XLEN-8){1'b0}}, b};
      LH:  begin data = {{(XLEN-16){h[15]}}, h}; ld_err = addr_lo[0]; end
      LHU: begin data = {{(XLEN-16){1'b0}}, h}; ld_err = addr_lo[0]; end
      LW:  begin data = {{(XLEN-32){w[31]}}, w}; ld_err = |addr_lo[1:0]; end
      LWU: begin data = {{(XLEN-32){1'b0}}, w}; ld_err = |addr_lo[1:0]; end
      LD:  begin data = rdata; ld_err = |addr_lo; end
      default: ld_err = 1'b1;
    endcase
  end
endmodule

// File: rtl/wb_stage.sv
// wb_stage: RV64 writeback stage; latches one retiring instruction, drives regfile/forwarding, counts retires, halts on EBREAK
module wb_stage
  import wb_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               mem_valid_i,
  output logic               mem_ready_o,
  input  logic [XLEN-1:0]    mem_pc_i,
  input  logic [31:0]        mem_inst_i,
  input  logic [RADDR_W-1:0] mem_rd_i,
  input  logic               mem_rd_wen_i,
  input  logic               mem_is_load_i,
  input  logic [2:0]         mem_ld_type_i,
  input  logic [2:0]         mem_addr_lo_i,
  input  logic [XLEN-1:0]    mem_alu_res_i,
  input  logic [XLEN-1:0]    mem_rdata_i,
  input  logic               hold_i,
  output logic               rf_wen_o,
  output logic [RADDR_W-1:0] rf_waddr_o,
  output logic [XLEN-1:0]    rf_wdata_o,
  output logic               fwd_valid_o,
  output logic [RADDR_W-1:0] fwd_rd_o,
  output logic [XLEN-1:0]    fwd_data_o,
  output logic               commit_o,
  output logic [XLEN-1:0]    commit_pc_o,
  output logic [31:0]        commit_inst_o,
  output logic [XLEN-1:0]    retire_cnt_o,
  output logic               ld_err_o,
  output logic               halt_o
);
  state_t state, state_nxt;
  logic wb_valid, wen, ld_err, al_err, accept;
  logic [RADDR_W-1:0] rd;
  logic [XLEN-1:0] wdata, pc, retire_cnt, al_data;
  logic [31:0] inst;
  wb_load_align u_align (
    .ld_type(mem_ld_type_i),
    .addr_lo(mem_addr_lo_i),
    .rdata(mem_rdata_i),
    .data(al_data),
    .ld_err(al_err)
  );
  assign mem_ready_o = (state == RUN) & ~hold_i & (rst != RST_ACTIVE);
  assign accept = mem_valid_i & mem_ready_o;
  always_comb begin
    state_nxt = (state == RUN && wb_valid && inst == EBREAK_INST) ? HALT : state;
  end
  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE) begin
      state <= RUN;
      wb_valid <= 1'b0;
      rd <= '0;
      wen <= 1'b0;
      wdata <= ZERO64;
      pc <= ZERO64;
      inst <= '0;
      retire_cnt <= ZERO64;
      ld_err <= 1'b0;
    end else begin
      state <= state_nxt;
      wb_valid <= accept;
      if (accept) begin
        rd <= mem_rd_i;
        wen <= mem_rd_wen_i;
        wdata <= mem_is_load_i ? al_data : mem_alu_res_i;
        pc <= mem_pc_i;
        inst <= mem_inst_i;
        ld_err <= mem_is_load_i & al_err;
      end
      if (wb_valid) retire_cnt <= retire_cnt + 64'd1;
    end
  end
  // x0 writes are dropped here so forwarding never bypasses a bogus x0 value
  assign rf_wen_o = wb_valid & (wen == WEN_ACTIVE) & (rd != '0);
  assign rf_waddr_o = rd;
  assign rf_wdata_o = wdata;
  assign fwd_valid_o = rf_wen_o;
  assign fwd_rd_o = rd;
  assign fwd_data_o = wdata;
  assign commit_o = wb_valid;
  assign commit_pc_o = pc;
  assign commit_inst_o = inst;
  assign retire_cnt_o = retire_cnt;
  assign ld_err_o = ld_err;
  assign halt_o = (state == HALT);
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: table-driven vectors for result formatting plus directed hold, halt and reset sequences
module tb_wb_stage;
  logic clk = 1'b0, rst = 1'b1;
  logic mem_valid_i = 1'b0, mem_ready_o;
  logic [63:0] mem_pc_i = '0;
  logic [31:0] mem_inst_i = '0;
  logic [4:0] mem_rd_i = '0;
  logic mem_rd_wen_i = 1'b0, mem_is_load_i = 1'b0;
  logic [2:0] mem_ld_type_i = '0, mem_addr_lo_i = '0;
  logic [63:0] mem_alu_res_i = '0, mem_rdata_i = '0;
  logic hold_i = 1'b0;
  logic rf_wen_o, fwd_valid_o, commit_o, ld_err_o, halt_o;
  logic [4:0] rf_waddr_o, fwd_rd_o;
  logic [63:0] rf_wdata_o, fwd_data_o, commit_pc_o, retire_cnt_o;
  logic [31:0] commit_inst_o;
  int checks = 0, errors = 0;
  longint unsigned n_commit = 0;

  wb_stage dut (
    .clk(clk), .rst(rst),
    .mem_valid_i(mem_valid_i), .mem_ready_o(mem_ready_o),
    .mem_pc_i(mem_pc_i), .mem_inst_i(mem_inst_i),
    .mem_rd_i(mem_rd_i), .mem_rd_wen_i(mem_rd_wen_i),
    .mem_is_load_i(mem_is_load_i), .mem_ld_type_i(mem_ld_type_i),
    .mem_addr_lo_i(mem_addr_lo_i), .mem_alu_res_i(mem_alu_res_i),
    .mem_rdata_i(mem_rdata_i), .hold_i(hold_i),
    .rf_wen_o(rf_wen_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
    .fwd_valid_o(fwd_valid_o), .fwd_rd_o(fwd_rd_o), .fwd_data_o(fwd_data_o),
    .commit_o(commit_o), .commit_pc_o(commit_pc_o), .commit_inst_o(commit_inst_o),
    .retire_cnt_o(retire_cnt_o), .ld_err_o(ld_err_o), .halt_o(halt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_load;
    logic [2:0]  ld_type;
    logic [2:0]  addr_lo;
    logic [63:0] rdata;
    logic [63:0] alu_res;
    logic [4:0]  rd;
    logic        rd_wen;
    logic        exp_wen;
    logic [63:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input logic [63:0] pc, input logic [31:0] inst);
    mem_valid_i = 1'b1;
    mem_pc_i = pc;
    mem_inst_i = inst;
    mem_rd_i = v.rd;
    mem_rd_wen_i = v.rd_wen;
    mem_is_load_i = v.is_load;
    mem_ld_type_i = v.ld_type;
    mem_addr_lo_i = v.addr_lo;
    mem_alu_res_i = v.alu_res;
    mem_rdata_i = v.rdata;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 3'b000, 3'd0, 64'h0, 64'h1234, 5'd5, 1'b1, 1'b1, 64'h1234, 1'b0};
    vecs[1]  = '{1'b1, 3'b000, 3'd3, 64'h0000_0000_80FF_7F00, 64'h0, 5'd6, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FF80, 1'b0};
    vecs[2]  = '{1'b1, 3'b100, 3'd3, 64'h0000_0000_80FF_7F00, 64'h0, 5'd6, 1'b1, 1'b1, 64'h0000_0000_0000_0080, 1'b0};
    vecs[3]  = '{1'b1, 3'b010, 3'd4, 64'h8000_0001_DEAD_BEEF, 64'h0, 5'd7, 1'b1, 1'b1, 64'hFFFF_FFFF_8000_0001, 1'b0};
    vecs[4]  = '{1'b1, 3'b110, 3'd4, 64'h8000_0001_DEAD_BEEF, 64'h0, 5'd7, 1'b1, 1'b1, 64'h0000_0000_8000_0001, 1'b0};
    vecs[5]  = '{1'b1, 3'b001, 3'd1, 64'h1122_3344_5566_7788, 64'h0, 5'd8, 1'b1, 1'b1, 64'h0000_0000_0000_7788, 1'b1};
    vecs[6]  = '{1'b1, 3'b011, 3'd0, 64'h0123_4567_89AB_CDEF, 64'h0, 5'd9, 1'b1, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b0};
    vecs[7]  = '{1'b1, 3'b011, 3'd4, 64'h0123_4567_89AB_CDEF, 64'h0, 5'd9, 1'b1, 1'b1, 64'h0123_4567_89AB_CDEF, 1'b1};
    vecs[8]  = '{1'b1, 3'b111, 3'd0, 64'h0123_4567_89AB_CDEF, 64'h0, 5'd10, 1'b1, 1'b1, 64'h0, 1'b1};
    vecs[9]  = '{1'b1, 3'b101, 3'd6, 64'hF00D_0000_0000_0000, 64'h0, 5'd11, 1'b1, 1'b1, 64'h0000_0000_0000_F00D, 1'b0};
    vecs[10] = '{1'b1, 3'b001, 3'd6, 64'hF00D_0000_0000_0000, 64'h0, 5'd11, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_F00D, 1'b0};
    vecs[11] = '{1'b0, 3'b000, 3'd0, 64'h0, 64'h55, 5'd0, 1'b1, 1'b0, 64'h55, 1'b0};
    vecs[12] = '{1'b0, 3'b111, 3'd5, 64'hFFFF, 64'hCAFE, 5'd12, 1'b0, 1'b0, 64'hCAFE, 1'b0};

    @(posedge clk); #1;
    chk("ready_in_rst", mem_ready_o, 0);
    @(negedge clk) rst = 1'b0;
    #1;
    chk("rst_commit", commit_o, 0);
    chk("rst_wen", rf_wen_o, 0);
    chk("rst_cnt", retire_cnt_o, 0);
    chk("rst_halt", halt_o, 0);
    chk("rst_err", ld_err_o, 0);
    chk("rst_ready", mem_ready_o, 1);

    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      drive(vecs[i], 64'h1000 + 64'(i) * 4, 32'h0000_0013);
      @(posedge clk); #1;
      mem_valid_i = 1'b0;
      chk($sformatf("v%0d_commit", i), commit_o, 1);
      chk($sformatf("v%0d_wen", i), rf_wen_o, vecs[i].exp_wen);
      chk($sformatf("v%0d_fwd_valid", i), fwd_valid_o, vecs[i].exp_wen);
      chk($sformatf("v%0d_waddr", i), rf_waddr_o, vecs[i].rd);
      chk($sformatf("v%0d_data", i), rf_wdata_o, vecs[i].exp_data);
      chk($sformatf("v%0d_fwd_data", i), fwd_data_o, vecs[i].exp_data);
      chk($sformatf("v%0d_err", i), ld_err_o, vecs[i].exp_err);
      chk($sformatf("v%0d_pc", i), commit_pc_o, 64'h1000 + 64'(i) * 4);
      chk($sformatf("v%0d_cnt", i), retire_cnt_o, n_commit);
      n_commit++;
    end
    @(posedge clk); #1;
    chk("bubble_commit", commit_o, 0);
    chk("cnt_after_table", retire_cnt_o, n_commit);

    // hold for two cycles with a valid instruction waiting
    @(negedge clk);
    hold_i = 1'b1;
    drive('{1'b0, 3'b000, 3'd0, 64'h0, 64'hAB, 5'd7, 1'b1, 1'b1, 64'hAB, 1'b0}, 64'h2000, 32'h0000_0013);
    #1 chk("hold_ready", mem_ready_o, 0);
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      chk($sformatf("hold_bubble%0d", c), commit_o, 0);
    end
    @(negedge clk) hold_i = 1'b0;
    @(posedge clk); #1;
    mem_valid_i = 1'b0;
    chk("hold_commit", commit_o, 1);
    chk("hold_data", rf_wdata_o, 64'hAB);
    chk("hold_waddr", rf_waddr_o, 5'd7);
    n_commit++;
    @(posedge clk); #1;
    chk("hold_once", commit_o, 0);
    chk("hold_cnt", retire_cnt_o, n_commit);

    // EBREAK commits, then the stage halts until reset
    @(negedge clk);
    drive('{1'b0, 3'b000, 3'd0, 64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 64'h0, 1'b0}, 64'h3000, 32'h0010_0073);
    @(posedge clk); #1;
    mem_valid_i = 1'b0;
    chk("ebrk_commit", commit_o, 1);
    chk("ebrk_inst", commit_inst_o, 32'h0010_0073);
    chk("ebrk_pc", commit_pc_o, 64'h3000);
    chk("ebrk_not_yet_halt", halt_o, 0);
    n_commit++;
    @(posedge clk); #1;
    chk("halt_set", halt_o, 1);
    chk("halt_ready", mem_ready_o, 0);
    chk("halt_cnt", retire_cnt_o, n_commit);
    @(negedge clk);
    drive('{1'b0, 3'b000, 3'd0, 64'h0, 64'h77, 5'd3, 1'b1, 1'b1, 64'h77, 1'b0}, 64'h3004, 32'h0000_0013);
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk($sformatf("halt_no_commit%0d", c), commit_o, 0);
      chk($sformatf("halt_hold%0d", c), halt_o, 1);
      chk($sformatf("halt_ready%0d", c), mem_ready_o, 0);
    end
    @(negedge clk) rst = 1'b1;
    #1 chk("rst_ready_low", mem_ready_o, 0);
    @(posedge clk); #1;
    chk("rst_halt_clr", halt_o, 0);
    chk("rst_cnt_clr", retire_cnt_o, 0);
    @(negedge clk) rst = 1'b0;
    #1 chk("post_rst_ready", mem_ready_o, 1);

    // reset right after an accept discards the latched instruction
    @(posedge clk); #1;
    mem_valid_i = 1'b0;
    chk("pre_rst_commit", commit_o, 1);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_discard_wen", rf_wen_o, 0);
    chk("rst_discard_commit", commit_o, 0);
    chk("rst_discard_cnt", retire_cnt_o, 0);
    @(negedge clk) rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
